// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified block memory's second port between the
// instruction-fetch refill path and the data-access path. One access at a time,
// round-robin under contention, fixed strobe hold, mandatory strobe-low release.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned LINE_BITS   = 64,
    parameter int unsigned MEM_LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    // instruction side
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [LINE_BITS-1:0] i_rdata,
    // data side
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [LINE_BITS-1:0] d_rdata,
    // memory port
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    // status
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 owner_d, owner_d_nxt;   // 1 = data side owns the access
    logic                 we_q, we_nxt;           // latched data-side write flag
    logic                 last_d, last_d_nxt;     // 1 = data side granted last
    logic                 grant_d;

    logic                 mem_read_nxt, mem_write_nxt;
    logic [WORD_SIZE-1:0] mem_addr_nxt;
    logic [LINE_BITS-1:0] mem_wdata_nxt;
    logic                 i_ack_nxt, d_ack_nxt;
    logic [LINE_BITS-1:0] i_rdata_nxt, d_rdata_nxt;
    logic                 busy_nxt;

    // Round-robin pick: data wins when alone or when instruction was granted last.
    assign grant_d = d_req && (!i_req || !last_d);

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        owner_d_nxt   = owner_d;
        we_nxt        = we_q;
        last_d_nxt    = last_d;
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        i_ack_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;

        unique case (state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    owner_d_nxt   = grant_d;
                    last_d_nxt    = grant_d;
                    we_nxt        = grant_d && d_we;
                    mem_addr_nxt  = grant_d ? d_addr : i_addr;
                    mem_wdata_nxt = grant_d ? LINE_BITS'(d_wdata) : '0;
                    cnt_nxt       = CNT_LOAD;
                    mem_read_nxt  = !(grant_d && d_we);
                    mem_write_nxt = grant_d && d_we;
                    state_nxt     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    // Last strobe cycle: capture the block, then drop strobes.
                    if (!we_q) begin
                        if (owner_d) begin
                            d_rdata_nxt = mem_rdata;
                        end else begin
                            i_rdata_nxt = mem_rdata;
                        end
                    end
                    i_ack_nxt = !owner_d;
                    d_ack_nxt = owner_d;
                    state_nxt = ST_RELEASE;
                end else begin
                    cnt_nxt       = cnt - CNT_W'(1);
                    mem_read_nxt  = !we_q;
                    mem_write_nxt = we_q;
                end
            end
            ST_RELEASE: begin
                // Strobes stay low here so the memory re-arms on the next rising edge.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            owner_d   <= 1'b0;
            we_q      <= 1'b0;
            last_d    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            owner_d   <= owner_d_nxt;
            we_q      <= we_nxt;
            last_d    <= last_d_nxt;
            mem_read  <= mem_read_nxt;
            mem_write <= mem_write_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            i_ack     <= i_ack_nxt;
            d_ack     <= d_ack_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a small
// fixed-latency block memory model.
module tb_mem_port_arbiter;

    localparam int unsigned WS  = 16;
    localparam int unsigned LB  = 64;
    localparam int          LAT = 8;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [WS-1:0] i_addr;
    logic          i_ack;
    logic [LB-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [WS-1:0] d_addr;
    logic [WS-1:0] d_wdata;
    logic          d_ack;
    logic [LB-1:0] d_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [WS-1:0] mem_addr;
    logic [LB-1:0] mem_wdata;
    logic [LB-1:0] mem_rdata;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    mem_port_arbiter #(
        .WORD_SIZE  (WS),
        .LINE_BITS  (LB),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data only valid in the last strobe cycle of a read burst.
    logic [15:0] mem [256];
    int          rd_cnt;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
            mem[8'h20] <= 16'h6000;
            mem[8'h21] <= 16'h4108;
            mem[8'h40] <= 16'h1111;
            mem[8'h41] <= 16'h2222;
            mem[8'h42] <= 16'h3333;
            mem[8'h43] <= 16'h4444;
            mem[8'h60] <= 16'h5555;
            mem[8'h80] <= 16'h0A0A;
            mem[8'h81] <= 16'h0B0B;
            mem[8'h82] <= 16'h0C0C;
            mem[8'h83] <= 16'h0D0D;
        end else if (mem_write) begin
            mem[mem_addr[7:0]] <= mem_wdata[15:0];
        end
        rd_cnt <= mem_read ? rd_cnt + 1 : 0;
    end

    assign mem_rdata = (mem_read && rd_cnt == LAT - 1) ?
        {mem[{mem_addr[7:2], 2'd3}], mem[{mem_addr[7:2], 2'd2}],
         mem[{mem_addr[7:2], 2'd1}], mem[{mem_addr[7:2], 2'd0}]} :
        64'hBAD0_BAD0_BAD0_BAD0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Safety invariants checked every cycle once reset has been applied.
    always @(negedge clk) begin
        if (mon_en)
            check("invariant", 64'({mem_read & mem_write, i_ack & d_ack,
                                    (mem_read | mem_write) & ~busy}), 64'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " flags"}, 64'({mem_read, mem_write, i_ack, d_ack, busy}), 64'd0);
        check({tag, " addr"}, 64'(mem_addr), 64'd0);
        check({tag, " wdata"}, mem_wdata, 64'd0);
        check({tag, " i_rdata"}, i_rdata, 64'd0);
        check({tag, " d_rdata"}, d_rdata, 64'd0);
    endtask

    // One IDLE cycle between accesses: nothing asserted.
    task automatic idle_cycle(input string tag);
        step();
        check({tag, " idle"}, 64'({mem_read, mem_write, i_ack, d_ack, busy}), 64'd0);
    endtask

    // Called at the start of the request-sampling cycle; returns in the ack cycle.
    task automatic run_txn(input string tag, input bit is_d, input bit we,
                           input logic [15:0] addr, input logic [63:0] wdata,
                           input logic [63:0] exp_i, input logic [63:0] exp_d,
                           input bit drop, input bit disturb);
        logic [4:0] exp_flags;
        for (int k = 1; k <= LAT + 1; k++) begin
            step();
            if (disturb && k == 2) begin
                d_addr = 16'h0080;
                i_req  = 1'b1;
            end
            if (disturb && k == 5) i_req = 1'b0;
            exp_flags = {(k <= LAT) && !we, (k <= LAT) && we,
                         (k == LAT + 1) && !is_d, (k == LAT + 1) && is_d, 1'b1};
            check($sformatf("%s flags c%0d", tag, k),
                  64'({mem_read, mem_write, i_ack, d_ack, busy}), 64'(exp_flags));
            if (k <= LAT)
                check($sformatf("%s addr c%0d", tag, k), 64'(mem_addr), 64'(addr));
            if (we && k == 1)
                check({tag, " wdata"}, mem_wdata, wdata);
            if (k == LAT + 1) begin
                check({tag, " i_rdata"}, i_rdata, exp_i);
                check({tag, " d_rdata"}, d_rdata, exp_d);
                if (drop) begin
                    if (is_d) d_req = 1'b0;
                    else      i_req = 1'b0;
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        step();
        step();
        check_reset("rst");
        reset  = 1'b0;
        mon_en = 1'b1;

        // Instruction block read
        i_req  = 1'b1;
        i_addr = 16'h0020;
        run_txn("i_rd", 0, 0, 16'h0020, 64'd0,
                64'h0000_0000_4108_6000, 64'd0, 1, 0);
        idle_cycle("i_rd");

        // Data word write, then block read of the same block
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0041;
        d_wdata = 16'hBEEF;
        run_txn("d_wr", 1, 1, 16'h0041, 64'h0000_0000_0000_BEEF,
                64'h0000_0000_4108_6000, 64'd0, 1, 0);
        d_we = 1'b0;
        idle_cycle("d_wr");
        d_req  = 1'b1;
        d_addr = 16'h0040;
        run_txn("d_rd", 1, 0, 16'h0040, 64'd0,
                64'h0000_0000_4108_6000, 64'h4444_3333_BEEF_1111, 1, 0);
        idle_cycle("d_rd");

        // Contention right after reset: data first, then instruction
        reset = 1'b1;
        step();
        check_reset("rst2");
        reset  = 1'b0;
        i_req  = 1'b1;
        i_addr = 16'h0020;
        d_req  = 1'b1;
        d_addr = 16'h0080;
        run_txn("cont_d", 1, 0, 16'h0080, 64'd0,
                64'd0, 64'h0D0D_0C0C_0B0B_0A0A, 1, 0);
        idle_cycle("cont_d");
        run_txn("cont_i", 0, 0, 16'h0020, 64'd0,
                64'h0000_0000_4108_6000, 64'h0D0D_0C0C_0B0B_0A0A, 1, 0);
        idle_cycle("cont_i");

        // Fairness with both sides requesting continuously: D, I, D, I
        i_req  = 1'b1;
        i_addr = 16'h0060;
        d_req  = 1'b1;
        d_addr = 16'h0040;
        run_txn("fair_d0", 1, 0, 16'h0040, 64'd0,
                64'h0000_0000_4108_6000, 64'h4444_3333_2222_1111, 0, 0);
        idle_cycle("fair_d0");
        run_txn("fair_i1", 0, 0, 16'h0060, 64'd0,
                64'h0000_0000_0000_5555, 64'h4444_3333_2222_1111, 0, 0);
        idle_cycle("fair_i1");
        run_txn("fair_d2", 1, 0, 16'h0040, 64'd0,
                64'h0000_0000_0000_5555, 64'h4444_3333_2222_1111, 0, 0);
        idle_cycle("fair_d2");
        run_txn("fair_i3", 0, 0, 16'h0060, 64'd0,
                64'h0000_0000_0000_5555, 64'h4444_3333_2222_1111, 0, 0);
        i_req = 1'b0;
        d_req = 1'b0;
        idle_cycle("fair_i3");

        // Request changes during an access are ignored
        d_req  = 1'b1;
        d_addr = 16'h0040;
        run_txn("ign", 1, 0, 16'h0040, 64'd0,
                64'h0000_0000_0000_5555, 64'h4444_3333_2222_1111, 1, 1);
        idle_cycle("ign_a");
        idle_cycle("ign_b");

        // Reset in the middle of an access aborts it without an ack
        i_req  = 1'b1;
        i_addr = 16'h0020;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("abort flags c%0d", k),
                  64'({mem_read, mem_write, i_ack, d_ack, busy}), 64'b10001);
        end
        reset = 1'b1;
        step();
        check_reset("rst_mid");
        reset = 1'b0;
        run_txn("post_rst", 0, 0, 16'h0020, 64'd0,
                64'h0000_0000_4108_6000, 64'd0, 1, 0);
        idle_cycle("post_rst");

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single read/write port of the unified 4-word-block memory between the instruction-fetch refill path and the data-access path of the pipelined CPU. Accepts one request at a time from each side, sequences the fixed-latency memory access (strobe hold, data capture, mandatory strobe release), and returns the 64-bit block or write completion with a one-cycle acknowledge. Sits between the I-/D-cache controllers and the memory's second port.

## Interface
- WORD_SIZE, 16, address and memory word width
- LINE_BITS, 64, block width (4 words)
- MEM_LATENCY, 8, cycles the memory strobe is held; memory data is sampled at the end of the last one (min 2)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction-side block read request; held until i_ack
- i_addr  in  WORD_SIZE  instruction block address
- i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle
- i_rdata  out  LINE_BITS  block returned to instruction side
- d_req  in  1  data-side request; held until d_ack
- d_we  in  1  1 = word write, 0 = block read
- d_addr  in  WORD_SIZE  data address (word address for writes)
- d_wdata  in  WORD_SIZE  word to write
- d_ack  out  1  one-cycle pulse; d_rdata valid in the same cycle for reads
- d_rdata  out  LINE_BITS  block returned to data side
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  WORD_SIZE  memory address
- mem_wdata  out  LINE_BITS  {48'b0, word}; driven only meaningful while mem_write=1
- mem_rdata  in  LINE_BITS  memory read block
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: if any req, grant one, latch addr/we/wdata and owner, load counter with MEM_LATENCY-1, go BUSY. Else stay.
- Arbitration: only one request -> grant it. Both -> grant the side not granted last (round-robin). Last-grant pointer resets to "instruction", so the first contended grant goes to data.
- BUSY: mem_read = owner reads, mem_write = owner is data with d_we=1; mem_addr/mem_wdata from latched values. Counter decrements each cycle; when counter==0: capture mem_rdata into the owner's rdata register (reads only), go RELEASE.
- RELEASE: both strobes low (memory re-arms its latency counter on strobe rising edge, so this cycle is mandatory); owner's ack = 1; go IDLE.
- Latched request is authoritative: req/addr changes during BUSY/RELEASE are ignored.
- rdata registers hold their value until the next capture for that side; the other side's rdata is never modified.
- Writes: d_rdata unchanged, d_ack still pulsed.
- Requester must drop or replace req in the cycle after ack; IDLE re-samples it then.

## Timing
- Reset (any state, including mid-BUSY): state=IDLE, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, i_ack=d_ack=0, i_rdata=d_rdata=0, busy=0, pointer=instruction, counter=0. An aborted access produces no ack.
- All outputs registered.
- Request sampled in IDLE cycle 0 -> strobes high cycles 1..MEM_LATENCY -> ack in cycle MEM_LATENCY+1 -> IDLE cycle MEM_LATENCY+2.
- Request-to-ack latency: MEM_LATENCY+1 cycles (9 at default). Back-to-back grant period: MEM_LATENCY+2 cycles (10).
- Strobes never high in RELEASE or IDLE; never both high.
- i_ack and d_ack never high in the same cycle.

## Test plan
- I read only: preload block 0x20..0x23 = {0x4108,0x6000,0x0,0x0}... i_req, i_addr=0x0020 at cycle 0 -> mem_read high cycles 1-8, i_ack cycle 9, i_rdata=64'h0000_0000_4108_6000 (memory order word3..word0), busy low cycle 10.
- D write then D read: d_we=1, d_addr=0x0041, d_wdata=0xBEEF -> mem_write cycles 1-8, mem_wdata=64'h0000_0000_0000_BEEF, d_ack cycle 9, d_rdata unchanged; then d_we=0, d_addr=0x0040 -> d_rdata[31:16]=0xBEEF.
- Contention after reset: i_req and d_req both high cycle 0 -> data granted first (d_ack cycle 9), instruction second (i_ack cycle 19); no cycle with both strobes or both acks.
- Fairness: both requesters re-request immediately after each ack for 4 grants -> grant order D, I, D, I; each strobe burst preceded by a strobe-low cycle.
- Reset mid-operation: i_req at cycle 0, reset high cycle 4 -> cycle 5 all outputs at reset values, no i_ack ever issued; with i_req still high after reset drops, fresh access completes 9 cycles later.
- Ignored changes: during BUSY change d_addr 0x0040->0x0080 and drop/raise i_req -> mem_addr stays 0x0040 through cycle 8, single d_ack only.
